// File: rtl/fifo_pkt_reader_pkg.sv
// Shared definitions for the FIFO packet reader.
// Holds the reader FSM state encoding and the output buffer depth.
package fifo_rd_pkg;

    // Reader FSM states: waiting for a command, popping words, waiting for eop to leave
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

    // Output skid buffer depth and the width of its occupancy counter
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    typedef logic [CNT_W-1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// Bus bundle of the FIFO packet reader: command handshake, show-ahead FIFO
// read port and Avalon-ST style source stream.
//   master : the reader itself (drives cmd_ready_o, fifo_rdreq_o, src_*, busy_o)
//   slave  : the surroundings (command source, FIFO, stream sink)
interface fifo_pkt_reader_if #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 9
);
    logic [LWIDTH-1:0] cmd_len_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [DWIDTH-1:0] fifo_q_i;
    logic              fifo_empty_i;
    logic              fifo_rdreq_o;
    logic [DWIDTH-1:0] src_data_o;
    logic              src_valid_o;
    logic              src_ready_i;
    logic              src_startofpacket_o;
    logic              src_endofpacket_o;
    logic              busy_o;

    modport master (
        input  cmd_len_i, cmd_valid_i, fifo_q_i, fifo_empty_i, src_ready_i,
        output cmd_ready_o, fifo_rdreq_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o, busy_o
    );

    modport slave (
        output cmd_len_i, cmd_valid_i, fifo_q_i, fifo_empty_i, src_ready_i,
        input  cmd_ready_o, fifo_rdreq_o, src_data_o, src_valid_o,
               src_startofpacket_o, src_endofpacket_o, busy_o
    );
endinterface

// File: rtl/fifo_pkt_reader_ast_skid_buf.sv
// Two-entry in-order skid buffer with registered outputs.
// Ports:
//   clk_i, srst_n_i          clock, synchronous active-low reset
//   in_data_i, in_valid_i    push side (caller guarantees no push when full)
//   out_data_o, out_valid_o  head entry, driven straight from registers
//   out_ready_i              sink accepts the head entry
//   cnt_o                    registered occupancy 0..2
module ast_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output buf_cnt_t         cnt_o
);
    localparam buf_cnt_t CNT_ZERO = {CNT_W{1'b0}};
    localparam buf_cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam buf_cnt_t CNT_FULL = CNT_W'(BUF_DEPTH);

    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] tail_r;
    buf_cnt_t         cnt_r;
    logic             valid_r;
    logic             take_s;

    assign take_s = valid_r & out_ready_i;

    // Occupancy and entry update; the head always holds the oldest word
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            valid_r <= 1'b0;
        end else begin
            case ({in_valid_i, take_s})
                2'b11: begin
                    // Push and transfer together: occupancy unchanged, queue shifts
                    if (cnt_r == CNT_FULL) begin
                        head_r <= tail_r;
                        tail_r <= in_data_i;
                    end else begin
                        head_r <= in_data_i;
                    end
                end
                2'b01: begin
                    if (cnt_r == CNT_FULL) begin
                        head_r <= tail_r;
                    end
                    cnt_r   <= cnt_r - CNT_ONE;
                    valid_r <= (cnt_r == CNT_FULL);
                end
                2'b10: begin
                    if (cnt_r == CNT_ZERO) begin
                        head_r <= in_data_i;
                    end else begin
                        tail_r <= in_data_i;
                    end
                    if (cnt_r < CNT_FULL) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                    valid_r <= 1'b1;
                end
                default: begin
                    cnt_r   <= cnt_r;
                    valid_r <= valid_r;
                end
            endcase
        end
    end

    assign out_data_o  = head_r;
    assign out_valid_o = valid_r;
    assign cnt_o       = cnt_r;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Reads length-prefixed packets out of a show-ahead FIFO and emits them as a
// sop/eop framed stream.  A command gives the word count of the next packet;
// words are popped while the output skid buffer has room and the FIFO is not
// empty, so the pop never depends combinationally on the sink's ready.
// Ports:
//   clk_i     rising-edge clock
//   srst_n_i  synchronous active-low reset
//   bus       fifo_pkt_reader_if.master (command, FIFO read port, stream, busy)
module fifo_pkt_reader
    import fifo_rd_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 9
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    fifo_pkt_reader_if.master bus
);
    localparam logic [LWIDTH-1:0] LEN_ZERO = {LWIDTH{1'b0}};
    localparam logic [LWIDTH-1:0] LEN_ONE  = {{(LWIDTH-1){1'b0}}, 1'b1};

    rd_state_e         state_r;
    logic [LWIDTH-1:0] remaining_r;
    logic              first_r;
    logic              cmd_ready_r;
    logic              busy_r;

    buf_cnt_t          buf_cnt_s;
    logic              pop_s;
    logic              cmd_acc_s;
    logic              eop_xfer_s;
    logic [DWIDTH+1:0] buf_in_s;
    logic [DWIDTH+1:0] buf_out_s;
    logic              buf_valid_s;

    // Pop decision from registered state and the FIFO flag only; gated by reset
    // so no word is lost from the FIFO while the reader is being cleared
    always_comb begin
        pop_s = 1'b0;
        if (srst_n_i && (state_r == STREAM) && (remaining_r != LEN_ZERO) &&
            !bus.fifo_empty_i && (buf_cnt_s < CNT_W'(BUF_DEPTH))) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign cmd_acc_s  = bus.cmd_valid_i & cmd_ready_r;
    assign buf_in_s   = {bus.fifo_q_i, first_r, (remaining_r == LEN_ONE)};
    assign eop_xfer_s = buf_valid_s & bus.src_ready_i & buf_out_s[0];

    // Reader FSM with its registered command-ready and busy outputs
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_r     <= IDLE;
            remaining_r <= LEN_ZERO;
            first_r     <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A zero-length command is consumed without leaving IDLE
                    if (cmd_acc_s && (bus.cmd_len_i != LEN_ZERO)) begin
                        remaining_r <= bus.cmd_len_i;
                        first_r     <= 1'b1;
                        state_r     <= STREAM;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end
                end
                STREAM: begin
                    if (pop_s) begin
                        remaining_r <= remaining_r - LEN_ONE;
                        first_r     <= 1'b0;
                        if (remaining_r == LEN_ONE) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Stay busy until the eop word has actually left the buffer
                    if (eop_xfer_s) begin
                        state_r     <= IDLE;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    remaining_r <= LEN_ZERO;
                    first_r     <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    ast_skid_buf #(
        .WIDTH(DWIDTH + 2)
    ) u_skid (
        .clk_i      (clk_i),
        .srst_n_i   (srst_n_i),
        .in_data_i  (buf_in_s),
        .in_valid_i (pop_s),
        .out_data_o (buf_out_s),
        .out_valid_o(buf_valid_s),
        .out_ready_i(bus.src_ready_i),
        .cnt_o      (buf_cnt_s)
    );

    assign bus.fifo_rdreq_o        = pop_s;
    assign bus.cmd_ready_o         = cmd_ready_r;
    assign bus.busy_o              = busy_r;
    assign bus.src_valid_o         = buf_valid_s;
    assign bus.src_data_o          = buf_out_s[DWIDTH+1:2];
    assign bus.src_startofpacket_o = buf_out_s[1];
    assign bus.src_endofpacket_o   = buf_out_s[0];

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;
    localparam int DW = 16;
    localparam int LW = 9;

    logic clk    = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_pkt_reader_if #(.DWIDTH(DW), .LWIDTH(LW)) pif ();

    fifo_pkt_reader #(.DWIDTH(DW), .LWIDTH(LW)) dut (
        .clk_i   (clk),
        .srst_n_i(srst_n),
        .bus     (pif)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- bench FIFO and reference model ----------------
    typedef struct packed { logic sop; logic eop; } flg_t;
    logic [DW-1:0] fifo[$];      // words currently in the show-ahead FIFO
    logic [DW-1:0] wq[$];        // words written and not yet seen on the output
    flg_t          fq[$];        // expected framing of words still to come out
    int pending  = 0;            // words of accepted packets not yet transferred
    int unpopped = 0;            // words of accepted packets not yet popped
    int occ      = 0;            // words popped but not yet transferred
    int cyc      = 0;
    int xfer_cnt = 0;
    int acc_cyc = -1, first_rd_cyc = -1, last_eop_cyc = -1;
    bit want_rd = 0;
    int            log_cyc[$];
    logic [DW-1:0] log_dat[$];
    logic          log_sop[$];
    logic          log_eop[$];
    bit            prev_stall = 0;
    logic [DW+1:0] prev_word;
    logic [DW-1:0] m_expd;
    flg_t          m_expf;
    logic [DW+1:0] m_word;
    int            m_len;

    // compare process: outputs are checked on the falling edge, then the model
    // advances by what happens at the following rising edge
    always @(negedge clk) begin
        cyc++;
        if (!srst_n) begin
            fq.delete();
            pending = 0; unpopped = 0; occ = 0; prev_stall = 0; want_rd = 0;
        end else begin
            m_word = {pif.src_data_o, pif.src_startofpacket_o, pif.src_endofpacket_o};
            chk("rdreq", 32'(pif.fifo_rdreq_o), 32'(unpopped > 0 && !pif.fifo_empty_i && occ < 2));
            if (pif.fifo_empty_i) chk("rdreq_on_empty", 32'(pif.fifo_rdreq_o), 32'd0);
            chk("valid", 32'(pif.src_valid_o), 32'(occ > 0));
            chk("busy", 32'(pif.busy_o), 32'(pending != 0));
            chk("cmd_ready", 32'(pif.cmd_ready_o), 32'(pending == 0));
            if (prev_stall) chk("stall_hold", 32'({pif.src_valid_o, m_word}), 32'({1'b1, prev_word}));
            prev_stall = pif.src_valid_o && !pif.src_ready_i;
            prev_word  = m_word;
            if (pif.src_valid_o && pif.src_ready_i) begin
                if (fq.size() == 0 || wq.size() == 0) begin
                    chk("unexpected_word", 32'(m_word), 32'hFFFFFFFF);
                end else begin
                    m_expd = wq.pop_front();
                    m_expf = fq.pop_front();
                    chk("word", 32'(m_word), 32'({m_expd, m_expf}));
                end
                log_cyc.push_back(cyc);
                log_dat.push_back(pif.src_data_o);
                log_sop.push_back(pif.src_startofpacket_o);
                log_eop.push_back(pif.src_endofpacket_o);
                if (pif.src_endofpacket_o) last_eop_cyc = cyc;
                pending--; occ--; xfer_cnt++;
            end
            if (pif.fifo_rdreq_o) begin
                unpopped--; occ++;
                chk("buf_occ_le2", 32'(occ <= 2), 32'd1);
                if (want_rd) begin first_rd_cyc = cyc; want_rd = 0; end
            end
            if (pif.cmd_valid_i && pif.cmd_ready_o) begin
                m_len   = int'(pif.cmd_len_i);
                acc_cyc = cyc;
                for (int i = 0; i < m_len; i++) fq.push_back('{sop: (i == 0), eop: (i == m_len - 1)});
                pending  += m_len;
                unpopped += m_len;
                want_rd   = (m_len > 0);
            end
        end
    end

    // ---------------- driver ----------------
    int rmode = 0;
    int rpat  = 0;
    bit feed  = 0;
    int owed  = 0;

    task automatic drive_fifo();
        pif.fifo_empty_i = (fifo.size() == 0);
        pif.fifo_q_i     = (fifo.size() != 0) ? fifo[0] : 16'hDEAD;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo.push_back(d);
        wq.push_back(d);
        drive_fifo();
    endtask

    task automatic flush_fifo();
        fifo.delete();
        wq.delete();
        drive_fifo();
    endtask

    task automatic clear_log();
        log_cyc.delete(); log_dat.delete(); log_sop.delete(); log_eop.delete();
    endtask

    // one clock: inputs change 1 time unit after the rising edge
    task automatic step();
        bit popq, acc;
        @(negedge clk);
        popq = pif.fifo_rdreq_o;
        acc  = pif.cmd_valid_i && pif.cmd_ready_o;
        @(posedge clk);
        #1;
        if (popq && fifo.size() != 0) void'(fifo.pop_front());
        if (acc) pif.cmd_valid_i = 1'b0;
        if (feed && owed > 0 && $urandom_range(0, 9) < 6) begin
            push_word(16'($urandom));
            owed--;
        end
        case (rmode)
            0:       pif.src_ready_i = 1'b1;
            1:       pif.src_ready_i = ((rpat % 3) == 0);
            default: pif.src_ready_i = 1'($urandom_range(0, 1));
        endcase
        rpat++;
        drive_fifo();
    endtask

    task automatic send_cmd(input int len);
        int t = 0;
        pif.cmd_len_i   = LW'(len);
        pif.cmd_valid_i = 1'b1;
        while (pif.cmd_valid_i && t < 200) begin step(); t++; end
        if (pif.cmd_valid_i) begin
            chk("cmd_accept_timeout", 32'd1, 32'd0);
            pif.cmd_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max);
        int t = 0;
        while ((pif.busy_o || pending != 0) && t < max) begin step(); t++; end
        if (t >= max) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        int pre;
        int len;
        pif.cmd_len_i   = {LW{1'b0}};
        pif.cmd_valid_i = 1'b0;
        pif.src_ready_i = 1'b1;
        drive_fifo();

        // reset state
        srst_n = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(pif.src_valid_o), 32'd0);
        chk("rst_sop", 32'(pif.src_startofpacket_o), 32'd0);
        chk("rst_eop", 32'(pif.src_endofpacket_o), 32'd0);
        chk("rst_busy", 32'(pif.busy_o), 32'd0);
        chk("rst_rdreq", 32'(pif.fifo_rdreq_o), 32'd0);
        chk("rst_cmd_ready", 32'(pif.cmd_ready_o), 32'd1);
        srst_n = 1'b1;
        step();

        // basic: 4 words back to back, latency 1 to pop and 2 to first word
        for (int i = 1; i <= 4; i++) push_word(16'(i));
        clear_log();
        send_cmd(4);
        wait_idle(50);
        chk("basic_busy_after", 32'(pif.busy_o), 32'd0);
        chk("basic_count", 32'(log_dat.size()), 32'd4);
        chk("basic_rd_latency", 32'(first_rd_cyc - acc_cyc), 32'd1);
        if (log_dat.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("basic_data", 32'(log_dat[i]), 32'(i + 1));
                chk("basic_cycle", 32'(log_cyc[i] - acc_cyc), 32'(i + 2));
                chk("basic_sop", 32'(log_sop[i]), 32'(i == 0));
                chk("basic_eop", 32'(log_eop[i]), 32'(i == 3));
            end
        end

        // back-pressure with ready pattern 1,0,0
        rmode = 1; rpat = 0;
        for (int i = 0; i < 6; i++) push_word(16'(16'h0100 + i));
        clear_log();
        send_cmd(6);
        wait_idle(200);
        rmode = 0;
        chk("bp_count", 32'(log_dat.size()), 32'd6);
        for (int i = 0; i < log_dat.size(); i++) chk("bp_data", 32'(log_dat[i]), 32'(16'h0100 + i));

        // starved FIFO: 2 words, 3 more 10 cycles later
        push_word(16'h0201); push_word(16'h0202);
        clear_log();
        send_cmd(5);
        repeat (10) step();
        push_word(16'h0203); push_word(16'h0204); push_word(16'h0205);
        wait_idle(100);
        chk("starve_count", 32'(log_dat.size()), 32'd5);
        for (int i = 0; i < log_dat.size(); i++) chk("starve_data", 32'(log_dat[i]), 32'(16'h0201 + i));

        // length 1 and length 0
        push_word(16'h0AAA);
        clear_log();
        send_cmd(1);
        wait_idle(50);
        chk("len1_count", 32'(log_dat.size()), 32'd1);
        if (log_dat.size() == 1) begin
            chk("len1_sop", 32'(log_sop[0]), 32'd1);
            chk("len1_eop", 32'(log_eop[0]), 32'd1);
        end
        push_word(16'h0BBB);
        clear_log();
        send_cmd(0);
        chk("len0_cmd_ready", 32'(pif.cmd_ready_o), 32'd1);
        chk("len0_busy", 32'(pif.busy_o), 32'd0);
        repeat (5) step();
        chk("len0_no_output", 32'(log_dat.size()), 32'd0);
        chk("len0_no_pop", 32'(fifo.size()), 32'd1);

        // reset after the 3rd transfer of an 8-word packet
        flush_fifo();
        for (int i = 0; i < 8; i++) push_word(16'(16'h0300 + i));
        base = xfer_cnt;
        send_cmd(8);
        t = 0;
        while (xfer_cnt < base + 3 && t < 100) begin step(); t++; end
        chk("mid_three_xfers", 32'(xfer_cnt - base), 32'd3);
        srst_n = 1'b0;
        flush_fifo();
        step();
        step();
        srst_n = 1'b1;
        chk("mid_rst_valid", 32'(pif.src_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(pif.busy_o), 32'd0);
        chk("mid_rst_cmd_ready", 32'(pif.cmd_ready_o), 32'd1);
        push_word(16'h0400); push_word(16'h0401);
        clear_log();
        send_cmd(2);
        wait_idle(50);
        chk("post_rst_count", 32'(log_dat.size()), 32'd2);
        if (log_dat.size() == 2) begin
            chk("post_rst_d0", 32'(log_dat[0]), 32'h0400);
            chk("post_rst_d1", 32'(log_dat[1]), 32'h0401);
            chk("post_rst_sop", 32'({log_sop[0], log_sop[1]}), 32'b10);
            chk("post_rst_eop", 32'({log_eop[0], log_eop[1]}), 32'b01);
        end

        // back-to-back commands 3 then 2
        for (int i = 0; i < 5; i++) push_word(16'(16'h0500 + i));
        clear_log();
        send_cmd(3);
        send_cmd(2);
        chk("b2b_after_eop", 32'(acc_cyc > last_eop_cyc), 32'd1);
        wait_idle(50);
        chk("b2b_count", 32'(log_dat.size()), 32'd5);
        if (log_dat.size() == 5) begin
            chk("b2b_sop", 32'({log_sop[0], log_sop[1], log_sop[2], log_sop[3], log_sop[4]}), 32'b10010);
            chk("b2b_eop", 32'({log_eop[0], log_eop[1], log_eop[2], log_eop[3], log_eop[4]}), 32'b00101);
        end

        // randomized packets, ready and FIFO fill
        feed = 1; rmode = 2;
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(0, 12);
            pre = $urandom_range(0, len);
            for (int i = 0; i < pre; i++) push_word(16'($urandom));
            owed += len - pre;
            send_cmd(len);
            wait_idle(600);
        end
        feed = 0; rmode = 0;
        step();
        chk("rand_fifo_drained", 32'(fifo.size()), 32'd0);
        chk("rand_words_left", 32'(wq.size()), 32'd0);
        chk("rand_flags_left", 32'(fq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 Parameter DWIDTH, default 16, data word width; equals the DWIDTH of the attached FIFO.
REQ-002 Parameter LWIDTH, default 9, packet-length field width; maximum packet length is 2**LWIDTH-1 words.
REQ-003 clk_i  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 srst_n_i  input  1  reset, synchronous, active-low.
REQ-005 cmd_len_i  input  LWIDTH  number of words in the next packet.
REQ-006 cmd_valid_i  input  1  cmd_len_i is valid.
REQ-007 cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
REQ-008 fifo_q_i  input  DWIDTH  show-ahead FIFO head word; valid whenever fifo_empty_i is low.
REQ-009 fifo_empty_i  input  1  FIFO empty flag.
REQ-010 fifo_rdreq_o  output  1  pops the FIFO head word.
REQ-011 src_data_o  output  DWIDTH  stream data.
REQ-012 src_valid_o  output  1  stream word valid.
REQ-013 src_ready_i  input  1  sink accepts the word; transfer occurs when valid and ready are both high.
REQ-014 src_startofpacket_o  output  1  marks the first word of a packet.
REQ-015 src_endofpacket_o  output  1  marks the last word of a packet.
REQ-016 busy_o  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, STREAM, DRAIN; cmd_ready_o SHALL be high only in IDLE.
REQ-018 IDLE: on command accept with cmd_len_i!=0, load remaining<=cmd_len_i, set first<=1, and go to STREAM; with cmd_len_i==0, accept, emit nothing, and stay in IDLE.
REQ-019 Pop rule: fifo_rdreq_o = (state==STREAM) && remaining!=0 && !fifo_empty_i && buf_cnt<2, where buf_cnt is the registered occupancy (0..2) of the output buffer.
REQ-020 fifo_rdreq_o SHALL have no combinational path from src_ready_i, and SHALL never assert while fifo_empty_i is high.
REQ-021 Each pop writes {fifo_q_i, sop=first, eop=(remaining==1)} into the output buffer, decrements remaining, and clears first.
REQ-022 STREAM -> DRAIN in the cycle the pop with remaining==1 occurs; DRAIN -> IDLE in the cycle the word with eop=1 transfers on the output.
REQ-023 The output buffer is a 2-entry skid buffer: src_* outputs are driven from registers, words leave in order, and simultaneous push and transfer keep buf_cnt unchanged.
REQ-024 Latency: a command accepted in cycle 0 with the FIFO non-empty gives fifo_rdreq_o high in cycle 1 and src_valid_o high with sop in cycle 2.
REQ-025 Throughput: with src_ready_i held high and the FIFO non-empty, one word per clock SHALL transfer.
REQ-026 src_valid_o high with src_ready_i low: src_data_o, sop and eop SHALL hold stable until the transfer.
REQ-027 FIFO runs empty mid-packet: popping pauses and resumes with no lost or duplicated words; the packet is not truncated.
REQ-028 A length-1 packet SHALL assert sop and eop on the same word.
REQ-029 src_startofpacket_o and src_endofpacket_o are meaningful only while src_valid_o is high.

Reset
REQ-030 While srst_n_i is low at a clock edge: state<=IDLE, remaining<=0, buf_cnt<=0, and src_valid_o, src_startofpacket_o, src_endofpacket_o, busy_o, and fifo_rdreq_o all 0; cmd_ready_o is 1 after reset.
REQ-031 Reset mid-packet SHALL discard the buffered words and the rest of the packet; no partial packet continues after reset is released.
REQ-032 src_data_o has no reset value requirement.

Structure
REQ-033 A shared package fifo_rd_pkg SHALL hold the state enum (IDLE, STREAM, DRAIN) and the buffer depth constant (2).
REQ-034 The output buffer SHALL be a sub-module named ast_skid_buf, parameterised by width (DWIDTH+2).

Verification
REQ-035 Basic: FIFO preloaded with 0x0001..0x0004, cmd_len=4, src_ready_i held high -> 4 consecutive words 0x0001..0x0004; sop on 0x0001, eop on 0x0004; busy_o low after eop.
REQ-036 Back-pressure: cmd_len=6, src_ready_i toggling 1,0,0,1,... -> all 6 words transfer in order with data stable while stalled, and buf_cnt never exceeds 2.
REQ-037 Starved FIFO: cmd_len=5 with only 2 words present, 3 more written 10 cycles later -> 5 words out with no duplicates, and fifo_rdreq_o never high while fifo_empty_i is high.
REQ-038 Edge lengths: cmd_len=1 -> a single word with sop=eop=1; cmd_len=0 -> no output and cmd_ready_o high the next cycle.
REQ-039 Reset mid-packet: cmd_len=8, srst_n_i low after the 3rd transfer -> src_valid_o=0 and state IDLE; a following cmd_len=2 yields a clean sop/eop packet.
REQ-040 Back-to-back: two commands (3, 2) -> the second is accepted only after the eop of the first; the output is 5 words with correct sop/eop placement.
